// File: rtl/carrier_sense_pkg.sv
// Shared types and widths for the carrier-sense energy detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carrier_sense_pkg;

    localparam int MAG_W  = 32;
    localparam int HANG_W = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2,
        HANG = 2'd3
    } cs_state_t;

    // Carrier is reported while busy or holding over.
    function automatic logic carrier_of(cs_state_t s);
        return (s == BUSY) || (s == HANG);
    endfunction

endpackage

// File: rtl/carrier_sense_detector_if.sv
// Sample/threshold/status bundle between the RX chain and the carrier-sense detector.
// Latency: n/a (wiring only). Optional stats signals exist when CS_STATS_EN is defined.
// Backpressure: none; samples are qualified by strobe only.
interface carrier_sense_detector_if #(parameter int SAMP_W = 16);
    import carrier_sense_pkg::*;

    logic                     strobe;
    logic                     run_rx;
    logic                     enable;
    logic signed [SAMP_W-1:0] i_in;
    logic signed [SAMP_W-1:0] q_in;
    logic [MAG_W-1:0]         thresh_on;
    logic [MAG_W-1:0]         thresh_off;
    logic [HANG_W-1:0]        hangover;
    logic                     carrier_present;
    logic [MAG_W-1:0]         power_avg;
    logic                     avg_valid;
`ifdef CS_STATS_EN
    logic                     stats_clear;
    logic [31:0]              busy_count;
`endif

    modport master (
        output strobe, run_rx, enable, i_in, q_in, thresh_on, thresh_off, hangover,
`ifdef CS_STATS_EN
        output stats_clear,
        input  busy_count,
`endif
        input  carrier_present, power_avg, avg_valid
    );

    modport slave (
        input  strobe, run_rx, enable, i_in, q_in, thresh_on, thresh_off, hangover,
`ifdef CS_STATS_EN
        input  stats_clear,
        output busy_count,
`endif
        output carrier_present, power_avg, avg_valid
    );

endinterface

// File: rtl/cs_moving_avg.sv
// 2^LOG2_WIN-deep moving average of |x|^2 with fill tracking.
// Latency: avg/avg_valid registered 1 clk after in_valid.
// Backpressure: none; flush clears the window immediately.
module cs_moving_avg
    import carrier_sense_pkg::*;
#(
    parameter int LOG2_WIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] mag2,
    output logic [MAG_W-1:0] avg,
    output logic             avg_valid
);

    localparam int N     = 1 << LOG2_WIN;
    localparam int ACC_W = MAG_W + LOG2_WIN;
    localparam logic [LOG2_WIN:0] N_CNT = (LOG2_WIN + 1)'(N);

    logic [MAG_W-1:0]  dline [N];
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [LOG2_WIN:0] fill;
    logic [LOG2_WIN:0] fill_nxt;

    // Running sum adds the newest sample and retires the one falling off the window.
    assign acc_nxt  = acc + ACC_W'(mag2) - ACC_W'(dline[N-1]);
    assign fill_nxt = (fill == N_CNT) ? fill : fill + 1'b1;

    // Window update on each accepted sample; flush empties the window like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc       <= '0;
            fill      <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            for (int k = 0; k < N; k++) dline[k] <= '0;
        end else if (in_valid) begin
            acc      <= acc_nxt;
            fill     <= fill_nxt;
            avg      <= MAG_W'(acc_nxt >> LOG2_WIN);
            avg_valid <= (fill_nxt == N_CNT);
            dline[0] <= mag2;
            for (int k = 1; k < N; k++) dline[k] <= dline[k-1];
        end
    end

endmodule

// File: rtl/carrier_sense_detector.sv
// RX energy detector: |I|^2+|Q|^2 -> moving average -> hysteresis/hangover FSM -> carrier_present.
// Latency: carrier_present updates 3 clk after the deciding strobe; power_avg/avg_valid after 2 clk.
// Backpressure: none; run_rx low flushes, enable low masks the flag. CS_STATS_EN adds busy_count/stats_clear.
module carrier_sense_detector
    import carrier_sense_pkg::*;
#(
    parameter int LOG2_WIN = 4,
    parameter int SAMP_W   = 16
) (
    input  logic clk,
    input  logic rst,
    carrier_sense_detector_if.slave bus
);

    logic signed [2*SAMP_W-1:0] i_sq;
    logic signed [2*SAMP_W-1:0] q_sq;
    logic [MAG_W-1:0]           mag2_nxt;
    logic [MAG_W-1:0]           mag2;
    logic                       stb_d1;
    logic                       stb_d2;
    logic [MAG_W-1:0]           avg;
    logic                       avg_valid;
    cs_state_t                  state;
    cs_state_t                  state_nxt;
    logic [HANG_W-1:0]          hang_cnt;
    logic [HANG_W-1:0]          hang_cnt_nxt;
    logic                       carrier_q;

    // Squares are non-negative and their sum peaks at 2^31, so the unsigned add cannot wrap.
    assign i_sq     = (2*SAMP_W)'(bus.i_in) * (2*SAMP_W)'(bus.i_in);
    assign q_sq     = (2*SAMP_W)'(bus.q_in) * (2*SAMP_W)'(bus.q_in);
    assign mag2_nxt = MAG_W'($unsigned(i_sq)) + MAG_W'($unsigned(q_sq));

    // Stage 1: register power of the new sample; stage valids drop while the chain is flushed.
    always_ff @(posedge clk) begin
        if (rst || !bus.run_rx) begin
            stb_d1 <= 1'b0;
            stb_d2 <= 1'b0;
            mag2   <= '0;
        end else begin
            stb_d1 <= bus.strobe;
            stb_d2 <= stb_d1;
            if (bus.strobe) mag2 <= mag2_nxt;
        end
    end

    // Stage 2: moving-average window.
    cs_moving_avg #(.LOG2_WIN(LOG2_WIN)) u_avg (
        .clk       (clk),
        .rst       (rst),
        .flush     (!bus.run_rx),
        .in_valid  (stb_d1),
        .mag2      (mag2),
        .avg       (avg),
        .avg_valid (avg_valid)
    );

    // Stage 3 decision: strict hysteresis with a hangover hold, evaluated once per sample.
    always_comb begin
        state_nxt    = state;
        hang_cnt_nxt = hang_cnt;
        if (stb_d2) begin
            case (state)
                FILL: if (avg_valid) state_nxt = IDLE;
                IDLE: if (avg > bus.thresh_on) state_nxt = BUSY;
                BUSY: if (avg < bus.thresh_off) begin
                    state_nxt    = HANG;
                    hang_cnt_nxt = bus.hangover;
                end
                HANG: begin
                    if (avg > bus.thresh_on)  state_nxt = BUSY;
                    else if (hang_cnt == '0)  state_nxt = IDLE;
                    else                      hang_cnt_nxt = hang_cnt - 1'b1;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // State register and flag; enable masks the flag every clk without touching the FSM.
    always_ff @(posedge clk) begin
        if (rst || !bus.run_rx) begin
            state     <= FILL;
            hang_cnt  <= '0;
            carrier_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            hang_cnt  <= hang_cnt_nxt;
            carrier_q <= bus.enable && carrier_of(state_nxt);
        end
    end

    assign bus.carrier_present = carrier_q;
    assign bus.power_avg       = avg;
    assign bus.avg_valid       = avg_valid;

`ifdef CS_STATS_EN
    logic [31:0] busy_cnt;

    // Occupancy counter: one count per evaluation spent busy or holding over, saturating.
    always_ff @(posedge clk) begin
        if (rst || bus.stats_clear)                                  busy_cnt <= '0;
        else if (stb_d2 && carrier_of(state) && (busy_cnt != '1))    busy_cnt <= busy_cnt + 1'b1;
    end

    assign bus.busy_count = busy_cnt;
`endif

endmodule
